// File: rtl/arb_req_ctrl.sv
// arb_req_ctrl: requester-side companion to a 4-way fixed-priority arbiter.
// Each channel accepts a job of job_len+1 beats, holds req until every beat
// has been granted, then drops req for at least one cycle and pulses done.
// Grants that move away mid-burst are tolerated (req stays high). Channels
// that wait too long for their first beat raise starve.
//
// Handshakes:
//   job_valid/job_ready : a job transfers on a rising edge where both are 1.
//   req/gnt             : a beat transfers in any cycle where req & gnt is 1
//                         (beat output). gnt while req is low is ignored.
module arb_req_ctrl #(
  parameter int NUM_CH     = 4,
  parameter int LEN_W      = 4,
  parameter int STARVE_LIM = 15
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CH-1:0]       job_valid,
  input  logic [NUM_CH*LEN_W-1:0] job_len,
  output logic [NUM_CH-1:0]       job_ready,
  output logic [NUM_CH-1:0]       req,
  input  logic [NUM_CH-1:0]       gnt,
  output logic [NUM_CH-1:0]       beat,
  output logic [NUM_CH-1:0]       done,
  output logic [NUM_CH-1:0]       starve,
  output logic                    gnt_err
);

  localparam int WC_W = $clog2(STARVE_LIM + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_OWN  = 2'd2
  } ch_state_e;

  // Per-channel state, visible for debug probes and bound checkers.
  ch_state_e ch_state [NUM_CH];

  logic gnt_err_q;

  assign beat    = req & gnt;
  assign gnt_err = gnt_err_q;

  // More than one grant bit in a cycle is flagged one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) gnt_err_q <= 1'b0;
    else        gnt_err_q <= |(gnt & (gnt - 1'b1));
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    ch_state_e        state_q, state_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic [WC_W-1:0]  wcnt_q, wcnt_d;
    logic             done_q, last_beat;
    logic             req_c, ready_c, starve_c, beat_c;

    assign ch_state[i]  = state_q;
    assign beat_c       = req_c & gnt[i];
    assign req[i]       = req_c;
    assign job_ready[i] = ready_c;
    assign starve[i]    = starve_c;
    assign done[i]      = done_q;

    // State, remaining-beat count, wait counter and done pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q <= ST_IDLE;
        rem_q   <= '0;
        wcnt_q  <= '0;
        done_q  <= 1'b0;
      end else begin
        state_q <= state_d;
        rem_q   <= rem_d;
        wcnt_q  <= wcnt_d;
        done_q  <= last_beat;
      end
    end

    // Next-state: accept in IDLE, count beats in WAIT/OWN, finish on rem==0.
    always_comb begin
      state_d   = state_q;
      rem_d     = rem_q;
      wcnt_d    = wcnt_q;
      last_beat = 1'b0;
      case (state_q)
        ST_IDLE: begin
          wcnt_d = '0;
          if (job_valid[i]) begin
            state_d = ST_WAIT;
            rem_d   = job_len[i*LEN_W +: LEN_W];
          end
        end
        ST_WAIT, ST_OWN: begin
          if (beat_c) begin
            wcnt_d = '0;
            if (rem_q == '0) begin
              last_beat = 1'b1;
              state_d   = ST_IDLE;
            end else begin
              rem_d   = rem_q - 1'b1;
              state_d = ST_OWN;
            end
          end else if (state_q == ST_WAIT && wcnt_q < WC_W'(STARVE_LIM)) begin
            // Only the wait for the first beat is timed; pre-emption in OWN is not.
            wcnt_d = wcnt_q + 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // Outputs decoded from the registered state.
    always_comb begin
      req_c    = (state_q != ST_IDLE);
      ready_c  = (state_q == ST_IDLE);
      starve_c = (state_q == ST_WAIT) && (wcnt_q >= WC_W'(STARVE_LIM));
    end
  end

endmodule

// File: tb/tb_arb_req_ctrl.sv
// Bench for arb_req_ctrl: directed scenarios followed by random traffic,
// every cycle compared against a beat-counting reference model.
module tb_arb_req_ctrl;
  localparam int NUM_CH     = 4;
  localparam int LEN_W      = 4;
  localparam int STARVE_LIM = 15;

  // Clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [NUM_CH-1:0]       job_valid;
  logic [NUM_CH*LEN_W-1:0] job_len;
  logic [NUM_CH-1:0]       job_ready;
  logic [NUM_CH-1:0]       req;
  logic [NUM_CH-1:0]       gnt;
  logic [NUM_CH-1:0]       beat;
  logic [NUM_CH-1:0]       done;
  logic [NUM_CH-1:0]       starve;
  logic                    gnt_err;

  arb_req_ctrl #(.NUM_CH(NUM_CH), .LEN_W(LEN_W), .STARVE_LIM(STARVE_LIM)) dut (
    .clk(clk), .rst_n(rst_n), .job_valid(job_valid), .job_len(job_len),
    .job_ready(job_ready), .req(req), .gnt(gnt), .beat(beat), .done(done),
    .starve(starve), .gnt_err(gnt_err)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: a channel is busy with some number of beats still owed.
  bit busy      [NUM_CH];
  int beats_left[NUM_CH];
  bit started   [NUM_CH];
  int waited    [NUM_CH];
  bit done_m    [NUM_CH];
  bit err_m;
  int beat_total[NUM_CH];

  function automatic void model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      busy[c] = 0; beats_left[c] = 0; started[c] = 0; waited[c] = 0; done_m[c] = 0;
    end
    err_m = 0;
  endfunction

  function automatic void model_edge();
    int ones;
    if (!rst_n) begin
      model_reset();
      return;
    end
    ones = 0;
    for (int c = 0; c < NUM_CH; c++) begin
      done_m[c] = 0;
      if (gnt[c]) ones++;
      if (busy[c]) begin
        if (gnt[c]) begin
          beat_total[c]++;
          beats_left[c]--;
          started[c] = 1;
          waited[c]  = 0;
          if (beats_left[c] == 0) begin
            busy[c]   = 0;
            done_m[c] = 1;
          end
        end else if (!started[c]) begin
          waited[c] = (waited[c] + 1 > STARVE_LIM) ? STARVE_LIM : waited[c] + 1;
        end
      end else if (job_valid[c]) begin
        busy[c]       = 1;
        beats_left[c] = int'(job_len[c*LEN_W +: LEN_W]) + 1;
        started[c]    = 0;
        waited[c]     = 0;
      end
    end
    err_m = (ones > 1);
  endfunction

  task automatic compare_all(input string where);
    logic [NUM_CH-1:0] e_req, e_rdy, e_beat, e_done, e_starve;
    for (int c = 0; c < NUM_CH; c++) begin
      e_req[c]    = busy[c];
      e_rdy[c]    = !busy[c];
      e_beat[c]   = busy[c] && gnt[c];
      e_done[c]   = done_m[c];
      e_starve[c] = busy[c] && !started[c] && (waited[c] >= STARVE_LIM);
    end
    check({where, ".req"},       32'(req),       32'(e_req));
    check({where, ".job_ready"}, 32'(job_ready), 32'(e_rdy));
    check({where, ".beat"},      32'(beat),      32'(e_beat));
    check({where, ".done"},      32'(done),      32'(e_done));
    check({where, ".starve"},    32'(starve),    32'(e_starve));
    check({where, ".gnt_err"},   32'(gnt_err),   32'(err_m));
  endtask

  // Driver: apply inputs just after an edge, check at negedge, advance model at edge.
  task automatic step(input string where, input logic [3:0] jv, input logic [15:0] jl,
                      input logic [3:0] g);
    job_valid = jv;
    job_len   = jl;
    gnt       = g;
    @(negedge clk);
    compare_all(where);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  function automatic logic [15:0] len_at(input int ch, input int len);
    return 16'(len) << (ch * LEN_W);
  endfunction

  initial begin
    logic [3:0]  rjv, rg;
    logic [15:0] rjl;
    int          base3;

    rst_n = 1'b0; job_valid = '1; job_len = '0; gnt = '0;
    model_reset();
    for (int c = 0; c < NUM_CH; c++) beat_total[c] = 0;
    #1;
    // 1 Reset with every job_valid high: nothing accepted
    repeat (3) step("reset", 4'hF, 16'h0, 4'h0);
    rst_n = 1'b1;

    // 2 Single job on ch1, 3 beats
    step("single", 4'b0010, len_at(1, 2), 4'h0);
    repeat (5) step("single", 4'h0, 16'h0, 4'b0010);

    // 3 Pre-emption on ch3, 4 beats total
    base3 = beat_total[3];
    step("preempt", 4'b1000, len_at(3, 3), 4'h0);
    step("preempt", 4'h0, 16'h0, 4'b1000);
    repeat (2) step("preempt", 4'h0, 16'h0, 4'b0001);
    repeat (5) step("preempt", 4'h0, 16'h0, 4'b1000);
    check("preempt.beats3", 32'(beat_total[3] - base3), 32'd4);

    // 4 Starvation on ch2, then cleared by the first beat
    step("starve", 4'b0100, len_at(2, 1), 4'h0);
    repeat (STARVE_LIM + 3) step("starve", 4'h0, 16'h0, 4'h0);
    check("starve.level", 32'(starve[2]), 32'd1);
    repeat (3) step("starve", 4'h0, 16'h0, 4'b0100);

    // 5 Back-to-back 1-beat jobs on ch0 with grant held high
    repeat (8) step("b2b", 4'b0001, len_at(0, 0), 4'b0001);
    step("b2b", 4'h0, 16'h0, 4'b0001);

    // 6 gnt_err, then reset in the middle of a job
    step("gnt_err", 4'h0, 16'h0, 4'b0011);
    step("gnt_err", 4'b0010, len_at(1, 5), 4'h0);
    repeat (2) step("midrst", 4'h0, 16'h0, 4'b0010);
    rst_n = 1'b0;
    #1;
    check("midrst.req",  32'(req),       32'd0);
    check("midrst.done", 32'(done),      32'd0);
    check("midrst.rdy",  32'(job_ready), 32'hF);
    model_reset();
    step("midrst", 4'h0, 16'h0, 4'b0010);
    rst_n = 1'b1;
    step("midrst", 4'h0, 16'h0, 4'b0010);

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      int r;
      rjv = 4'($urandom_range(0, 15));
      rjl = 16'h0;
      for (int c = 0; c < NUM_CH; c++)
        rjl |= len_at(c, ($urandom_range(0, 9) == 0) ? 15 : $urandom_range(0, 4));
      r = $urandom_range(0, 9);
      if (r <= 5)      rg = 4'(1 << $urandom_range(0, 3));
      else if (r <= 8) rg = 4'h0;
      else             rg = 4'($urandom_range(0, 15));
      step("random", rjv, rjl, rg);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
